// File: rtl/scene_renderer_pkg.sv
// Shared constants for the scene renderer: FSM encodings, colours, screen size,
// object reset positions and the box-overlap test.
package scene_renderer_pkg;

   typedef logic [9:0] coord_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ERASE  = 3'd1;
   localparam logic [2:0] ST_UPDATE = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_LATCH  = 3'd4;
   localparam logic [2:0] ST_DRAW   = 3'd5;

   localparam logic [2:0] COL_BG    = 3'b000;
   localparam logic [2:0] COL_PLANE = 3'b111;
   localparam logic [2:0] COL_LAVA  = 3'b100;
   localparam logic [2:0] COL_MTN   = 3'b010;

   localparam int SCREEN_W_PX = 640;
   localparam int SCREEN_H_PX = 480;

   // Box index order: 0 plane, 1 lava, 2 mountain 1, 3 mountain 2
   function automatic coord_t rst_x(input logic [1:0] idx);
      case (idx)
         2'd0:    rst_x = 10'd60;
         2'd1:    rst_x = 10'd550;
         2'd2:    rst_x = 10'd300;
         default: rst_x = 10'd500;
      endcase
   endfunction

   function automatic coord_t rst_y(input logic [1:0] idx);
      case (idx)
         2'd0:    rst_y = 10'd50;
         2'd1:    rst_y = 10'd100;
         default: rst_y = 10'd150;
      endcase
   endfunction

   // Strict inequalities: boxes that merely share an edge do not overlap
   function automatic logic boxes_overlap(
      input coord_t ax, input coord_t ay, input coord_t aw, input coord_t ah,
      input coord_t bx, input coord_t by, input coord_t bw, input coord_t bh);
      logic [10:0] ax_e, ay_e, bx_e, by_e;
      ax_e = {1'b0, ax} + {1'b0, aw};
      ay_e = {1'b0, ay} + {1'b0, ah};
      bx_e = {1'b0, bx} + {1'b0, bw};
      by_e = {1'b0, by} + {1'b0, bh};
      boxes_overlap = ({1'b0, ax} < bx_e) && ({1'b0, bx} < ax_e) &&
                      ({1'b0, ay} < by_e) && ({1'b0, by} < ay_e);
   endfunction

endpackage

// File: rtl/scene_renderer_box_scanner.sv
// Walks a w x h box row-major, one pixel per cycle; done marks the last pixel.
// Coordinates are 11 bits so off-screen sums never wrap back onto the screen.
module box_scanner
   import scene_renderer_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  coord_t      base_x,
   input  coord_t      base_y,
   input  coord_t      w,
   input  coord_t      h,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        valid,
   output logic        done
);

   logic [9:0] cx_reg;
   logic [9:0] cy_reg;
   logic       active_reg;
   logic       last_col;
   logic       last_row;

   assign last_col = (cx_reg == w - 10'd1);
   assign last_row = (cy_reg == h - 10'd1);
   assign valid    = active_reg;
   assign done     = active_reg && last_col && last_row;
   assign x        = {1'b0, base_x} + {1'b0, cx_reg};
   assign y        = {1'b0, base_y} + {1'b0, cy_reg};

   // start wins over the final pixel so back-to-back boxes have no gap
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         active_reg <= 1'b0;
         cx_reg     <= '0;
         cy_reg     <= '0;
      end else if (start) begin
         active_reg <= 1'b1;
         cx_reg     <= '0;
         cy_reg     <= '0;
      end else if (active_reg) begin
         if (last_col) begin
            cx_reg <= '0;
            if (last_row) active_reg <= 1'b0;
            else          cy_reg     <= cy_reg + 10'd1;
         end else begin
            cx_reg <= cx_reg + 10'd1;
         end
      end
   end

endmodule

// File: rtl/scene_renderer.sv
// Per frame: erase old sprites, step the objects, latch new positions, check
// collisions, then draw all four boxes through the VGA pixel interface.
module scene_renderer
   import scene_renderer_pkg::*;
#(
   parameter int SPRITE_W = 16,
   parameter int SPRITE_H = 16,
   parameter int MTN_W    = 16,
   parameter int MTN_H    = 80,
   parameter int PLANE_X  = 60,
   parameter int SCREEN_W = SCREEN_W_PX,
   parameter int SCREEN_H = SCREEN_H_PX
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       frame_tick,
   input  logic [9:0] plane_y,
   input  logic [9:0] lava_x,
   input  logic [9:0] lava_y,
   input  logic [9:0] mountain1_x,
   input  logic [9:0] mountain1_y,
   input  logic [9:0] mountain2_x,
   input  logic [9:0] mountain2_y,
   output logic       update_en,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       game_over
);

   localparam coord_t SW10 = 10'(SPRITE_W);
   localparam coord_t SH10 = 10'(SPRITE_H);
   localparam coord_t MW10 = 10'(MTN_W);
   localparam coord_t MH10 = 10'(MTN_H);
   localparam coord_t PX10 = 10'(PLANE_X);

   logic [2:0]  state_reg, state_next;
   logic [1:0]  idx_reg, idx_next;
   logic        scan_start;
   logic        game_over_reg;
   coord_t      in_x [4];
   coord_t      in_y [4];
   coord_t      obj_x_reg [4];
   coord_t      obj_y_reg [4];
   coord_t      box_w [4];
   coord_t      box_h [4];
   logic [2:0]  box_col [4];
   logic [2:0]  hit;
   logic [10:0] s_x, s_y;
   logic        s_valid, s_done;
   logic        in_screen;

   assign in_x[0] = PX10;
   assign in_y[0] = plane_y;
   assign in_x[1] = lava_x;
   assign in_y[1] = lava_y;
   assign in_x[2] = mountain1_x;
   assign in_y[2] = mountain1_y;
   assign in_x[3] = mountain2_x;
   assign in_y[3] = mountain2_y;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_box
         assign box_w[gi]   = (gi < 2) ? SW10 : MW10;
         assign box_h[gi]   = (gi < 2) ? SH10 : MH10;
         assign box_col[gi] = (gi == 0) ? COL_PLANE : ((gi == 1) ? COL_LAVA : COL_MTN);
      end
      for (gi = 1; gi < 4; gi++) begin : g_hit
         assign hit[gi-1] = boxes_overlap(in_x[0], in_y[0], box_w[0], box_h[0],
                                          in_x[gi], in_y[gi], box_w[gi], box_h[gi]);
      end
   endgenerate

   box_scanner u_scanner (
      .clk    (clk),
      .resetn (resetn),
      .start  (scan_start),
      .base_x (obj_x_reg[idx_reg]),
      .base_y (obj_y_reg[idx_reg]),
      .w      (box_w[idx_reg]),
      .h      (box_h[idx_reg]),
      .x      (s_x),
      .y      (s_y),
      .valid  (s_valid),
      .done   (s_done)
   );

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      scan_start = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (frame_tick) begin
               state_next = ST_ERASE;
               idx_next   = 2'd0;
               scan_start = 1'b1;
            end
         end
         ST_ERASE, ST_DRAW: begin
            if (s_done) begin
               if (idx_reg == 2'd3) begin
                  state_next = (state_reg == ST_ERASE) ? ST_UPDATE : ST_IDLE;
               end else begin
                  idx_next   = idx_reg + 2'd1;
                  scan_start = 1'b1;
               end
            end
         end
         ST_UPDATE: state_next = ST_WAIT;
         ST_WAIT:   state_next = ST_LATCH;
         ST_LATCH: begin
            state_next = ST_DRAW;
            idx_next   = 2'd0;
            scan_start = 1'b1;
         end
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= 2'd0;
         game_over_reg <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            obj_x_reg[i] <= rst_x(2'(i));
            obj_y_reg[i] <= rst_y(2'(i));
         end
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         if (state_reg == ST_LATCH) begin
            game_over_reg <= game_over_reg | (|hit);
            for (int i = 0; i < 4; i++) begin
               obj_x_reg[i] <= in_x[i];
               obj_y_reg[i] <= in_y[i];
            end
         end
      end
   end

   assign in_screen = (s_x < 11'(SCREEN_W)) && (s_y < 11'(SCREEN_H));
   assign plot      = s_valid && in_screen &&
                      ((state_reg == ST_ERASE) || (state_reg == ST_DRAW));
   assign x         = s_valid ? s_x[9:0] : 10'd0;
   assign y         = s_valid ? s_y[9:0] : 10'd0;
   assign colour    = (s_valid && state_reg == ST_DRAW) ? box_col[idx_reg] : COL_BG;
   assign busy      = (state_reg != ST_IDLE);
   assign update_en = (state_reg == ST_UPDATE) && !game_over_reg;
   assign game_over = game_over_reg;

endmodule
